// File: rtl/predicate_mask_sequencer.sv
// -----------------------------------------------------------------------------
// predicate_mask_sequencer
//
// This block is a command-driven sequencer for a 32x32x1 predicate register file.
// Each accepted command walks element indices 0..VL-1 of one predicate register.
// It drives the RF's single combinational read port and its single write port.
//
// Supported operations:
//   CLEAR   writes 0 to dst[0..VL-1].
//   SETALL  writes 1 to dst[0..VL-1].
//   COPY    dst[i] = src[i].
//   NOT     dst[i] = ~src[i]. src == dst is legal because each element is read
//           and written in the same cycle.
//   READ    streams src[0..VL-1] out on a valid/ready bit stream (rd_*).
//   WRITE   takes bits from a valid/ready bit stream (wr_*) into dst[0..VL-1].
//   NOP     (op 6/7) completes immediately.
//
// Optional feature (macro PRED_SEQ_POPCOUNT_EN):
//   Adds the output popcount. It is the number of 1 source bits consumed by
//   COPY/NOT/READ. It clears on command accept, is valid while done=1, and holds
//   until the next accept. When the macro is undefined, the port and the counter
//   are absent.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_op/src/dst/vl          opcode, source reg, destination reg, element count
//                              (cmd_vl is clamped to NUM_REGISTERS)
//   rf_read_addr1/2            RF read {register, element}
//   rf_data_out                RF combinational read data
//   rf_write_addr1/2           RF write {register, element}
//   rf_write_enable/rf_data_in RF write strobe and data
//   rd_valid/rd_ready          READ stream handshake
//   rd_bit/rd_last             READ stream bit; rd_last marks element VL-1
//   wr_valid/wr_ready/wr_bit   WRITE stream handshake and bit
//   done                       one-cycle completion pulse
//   popcount                   (PRED_SEQ_POPCOUNT_EN only) source one-count
// -----------------------------------------------------------------------------
module predicate_mask_sequencer #(
    parameter int ADDR_WIDTH    = 5,
    parameter int NUM_REGISTERS = 32,
    parameter int VL_WIDTH      = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_src,
    input  logic [ADDR_WIDTH-1:0] cmd_dst,
    input  logic [VL_WIDTH-1:0]   cmd_vl,
    output logic [ADDR_WIDTH-1:0] rf_read_addr1,
    output logic [ADDR_WIDTH-1:0] rf_read_addr2,
    input  logic                  rf_data_out,
    output logic [ADDR_WIDTH-1:0] rf_write_addr1,
    output logic [ADDR_WIDTH-1:0] rf_write_addr2,
    output logic                  rf_write_enable,
    output logic                  rf_data_in,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_bit,
    output logic                  rd_last,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  wr_bit,
    output logic                  done
`ifdef PRED_SEQ_POPCOUNT_EN
    ,
    output logic [VL_WIDTH-1:0]   popcount
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_CLEAR  = 3'd0,
        OP_SETALL = 3'd1,
        OP_COPY   = 3'd2,
        OP_NOT    = 3'd3,
        OP_READ   = 3'd4,
        OP_WRITE  = 3'd5,
        OP_NOP6   = 3'd6,
        OP_NOP7   = 3'd7
    } op_e;

    localparam logic [VL_WIDTH-1:0] VL_MAX = VL_WIDTH'(NUM_REGISTERS);

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [VL_WIDTH-1:0]   vl_q, vl_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;

    logic [VL_WIDTH-1:0]   vl_clamped;
    logic                  cmd_is_nop;
    logic                  is_last;
    logic                  advance;

    assign vl_clamped = (cmd_vl > VL_MAX) ? VL_MAX : cmd_vl;
    assign cmd_is_nop = (cmd_op == OP_NOP6) || (cmd_op == OP_NOP7);

    // vl_q is at least 1 whenever RUN is active, so vl_q - 1 never wraps there.
    assign is_last = (VL_WIDTH'(idx_q) == (vl_q - VL_WIDTH'(1)));

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statements can leave one unassigned (no latches).
        state_d         = state_q;
        op_d            = op_q;
        src_d           = src_q;
        dst_d           = dst_q;
        vl_d            = vl_q;
        idx_d           = idx_q;
        advance         = 1'b0;

        cmd_ready       = 1'b0;
        rf_read_addr1   = '0;
        rf_read_addr2   = '0;
        rf_write_addr1  = '0;
        rf_write_addr2  = '0;
        rf_write_enable = 1'b0;
        rf_data_in      = 1'b0;
        rd_valid        = 1'b0;
        rd_bit          = 1'b0;
        rd_last         = 1'b0;
        wr_ready        = 1'b0;
        done            = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // cmd_ready is gated by reset so that every output reads 0
                // while reset is asserted.
                cmd_ready = !reset;
                if (cmd_valid && !reset) begin
                    op_d  = op_e'(cmd_op);
                    src_d = cmd_src;
                    dst_d = cmd_dst;
                    vl_d  = vl_clamped;
                    idx_d = '0;
                    if ((vl_clamped == '0) || cmd_is_nop) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                rf_read_addr1  = src_q;
                rf_read_addr2  = idx_q;
                rf_write_addr1 = dst_q;
                rf_write_addr2 = idx_q;

                case (op_q)
                    OP_CLEAR: begin
                        rf_write_enable = 1'b1;
                        rf_data_in      = 1'b0;
                        advance         = 1'b1;
                    end
                    OP_SETALL: begin
                        rf_write_enable = 1'b1;
                        rf_data_in      = 1'b1;
                        advance         = 1'b1;
                    end
                    OP_COPY: begin
                        rf_write_enable = 1'b1;
                        rf_data_in      = rf_data_out;
                        advance         = 1'b1;
                    end
                    OP_NOT: begin
                        rf_write_enable = 1'b1;
                        rf_data_in      = ~rf_data_out;
                        advance         = 1'b1;
                    end
                    OP_READ: begin
                        // The bit stays presented until the consumer takes it.
                        rd_valid = 1'b1;
                        rd_bit   = rf_data_out;
                        rd_last  = is_last;
                        advance  = rd_ready;
                    end
                    OP_WRITE: begin
                        wr_ready = 1'b1;
                        if (wr_valid) begin
                            rf_write_enable = 1'b1;
                            rf_data_in      = wr_bit;
                            advance         = 1'b1;
                        end
                    end
                    default: begin
                        // NOPs never enter RUN. Draining keeps the FSM from
                        // sticking here if that ever happened.
                        advance = 1'b1;
                    end
                endcase

                if (advance) begin
                    if (is_last) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + ADDR_WIDTH'(1);
                    end
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: the whole control context has an async reset. Reset can abort a
    // command at any point, and the RF strobes are decoded from state_q, so
    // they must drop the instant reset rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_CLEAR;
            src_q   <= '0;
            dst_q   <= '0;
            vl_q    <= '0;
            idx_q   <= '0;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so
            // every flop samples pre-edge values.
            state_q <= state_d;
            op_q    <= op_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            vl_q    <= vl_d;
            idx_q   <= idx_d;
        end
    end

`ifdef PRED_SEQ_POPCOUNT_EN
    // -------------------------------------------------------------------------
    // Source one-count for COPY/NOT/READ
    // -------------------------------------------------------------------------
    logic [VL_WIDTH-1:0] pop_q, pop_d;
    logic                src_consumed;

    always_comb begin
        pop_d        = pop_q;
        // A source bit counts as consumed only on the cycle its element
        // advances. For READ, that means stalled cycles are not counted twice.
        src_consumed = (state_q == ST_RUN) && advance &&
                       ((op_q == OP_COPY) || (op_q == OP_NOT) || (op_q == OP_READ));
        if (cmd_valid && cmd_ready) begin
            pop_d = '0;
        end else if (src_consumed && rf_data_out) begin
            pop_d = pop_q + VL_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pop_q <= '0;
        end else begin
            pop_q <= pop_d;
        end
    end

    assign popcount = pop_q;
`endif

endmodule
